// File: rtl/mul_div_arb_pkg.sv
// Shared types and widths for the multiply/divide arbiter.
// Optional feature macro: MUL_DIV_ARB_DIVZ_CHK_EN (divide-by-zero interception).
package mul_div_arb_pkg;

    localparam int DIVIDEND_W = 50;
    localparam int OPB_W      = 24;
    localparam int PROD_W     = 48;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

    // Per-cycle pipeline tag travelling alongside the shared units.
    typedef struct packed {
        logic valid;
        logic id;
        op_e  op;
`ifdef MUL_DIV_ARB_DIVZ_CHK_EN
        logic dz;
`endif
    } tag_t;

endpackage

// File: rtl/mul_div_arb_rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational, pointer is registered.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr_r;

    // Grant selection: lone requester wins, on contention the pointer decides.
    always_comb begin
        gnt = 2'b00;
        if (rst) begin
            gnt = 2'b00;
        end else begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr_r ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Pointer moves to the other requester after every grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= 1'b0;
        end else if (gnt[0]) begin
            ptr_r <= 1'b1;
        end else if (gnt[1]) begin
            ptr_r <= 1'b0;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/mul_div_arb.sv
// Two-requester front end sharing one multiplier and one divider.
// Optional feature macro: MUL_DIV_ARB_DIVZ_CHK_EN (divide-by-zero interception).
module mul_div_arb
    import mul_div_arb_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_op,
    input  logic [DIVIDEND_W-1:0] req_opa0,
    input  logic [DIVIDEND_W-1:0] req_opa1,
    input  logic [OPB_W-1:0]      req_opb0,
    input  logic [OPB_W-1:0]      req_opb1,
    output logic [OPB_W-1:0]      mul_opa,
    output logic [OPB_W-1:0]      mul_opb,
    output logic [DIVIDEND_W-1:0] div_opa,
    output logic [OPB_W-1:0]      div_opb,
    input  logic [PROD_W-1:0]     mul_prod,
    input  logic [DIVIDEND_W-1:0] div_quo,
    input  logic [DIVIDEND_W-1:0] div_rem,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic [DIVIDEND_W-1:0] rsp_quo,
    output logic [DIVIDEND_W-1:0] rsp_rem,
    output logic                  busy
`ifdef MUL_DIV_ARB_DIVZ_CHK_EN
    ,
    output logic                  rsp_dz
`endif
);

    logic [1:0]            gnt_s;
    logic                  gnt_any_s;
    logic                  gnt_id_s;
    op_e                   gnt_op_s;
    logic [DIVIDEND_W-1:0] gnt_opa_s;
    logic [OPB_W-1:0]      gnt_opb_s;
    logic                  mul_upd_s;
    logic                  div_upd_s;
    tag_t                  tag_in_s;
    tag_t                  tag_out_s;
    tag_t                  tag_r [LAT];
`ifdef MUL_DIV_ARB_DIVZ_CHK_EN
    logic                  gnt_dz_s;
    logic [DIVIDEND_W-1:0] dz_opa_r [LAT];
`endif

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_valid),
        .gnt (gnt_s)
    );

    assign req_ready = gnt_s;
    assign tag_out_s = tag_r[LAT-1];

    // Mux the winning requester's operation and build the tag for this cycle.
    always_comb begin
        gnt_any_s = gnt_s[0] | gnt_s[1];
        gnt_id_s  = gnt_s[1];
        if (gnt_s[1]) begin
            gnt_op_s  = op_e'(req_op[1]);
            gnt_opa_s = req_opa1;
            gnt_opb_s = req_opb1;
        end else begin
            gnt_op_s  = op_e'(req_op[0]);
            gnt_opa_s = req_opa0;
            gnt_opb_s = req_opb0;
        end
        mul_upd_s = gnt_any_s && (gnt_op_s == OP_MUL);
        tag_in_s       = '0;
        tag_in_s.valid = gnt_any_s;
        tag_in_s.id    = gnt_id_s;
        tag_in_s.op    = gnt_op_s;
`ifdef MUL_DIV_ARB_DIVZ_CHK_EN
        // A zero divisor never reaches the divider; the answer is synthesised at the output.
        gnt_dz_s    = gnt_any_s && (gnt_op_s == OP_DIV) && (gnt_opb_s == 24'd0);
        tag_in_s.dz = gnt_dz_s;
        div_upd_s   = gnt_any_s && (gnt_op_s == OP_DIV) && !gnt_dz_s;
`else
        div_upd_s   = gnt_any_s && (gnt_op_s == OP_DIV);
`endif
    end

    // Unit operand registers; only the unit selected by the grant is loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_opa <= 24'd0;
            mul_opb <= 24'd0;
            div_opa <= 50'd0;
            div_opb <= 24'd0;
        end else begin
            if (mul_upd_s) begin
                mul_opa <= gnt_opa_s[OPB_W-1:0];
                mul_opb <= gnt_opb_s;
            end
            if (div_upd_s) begin
                div_opa <= gnt_opa_s;
                div_opb <= gnt_opb_s;
            end
        end
    end

    // Tag shift register matching the unit latency; reset drops in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                tag_r[i] <= '0;
            end
        end else begin
            tag_r[0] <= tag_in_s;
            for (int i = 1; i < LAT; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

`ifdef MUL_DIV_ARB_DIVZ_CHK_EN
    // Dividend carried alongside the tag so a zero-divisor result can return it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                dz_opa_r[i] <= 50'd0;
            end
        end else begin
            dz_opa_r[0] <= gnt_opa_s;
            for (int i = 1; i < LAT; i++) begin
                dz_opa_r[i] <= dz_opa_r[i-1];
            end
        end
    end
`endif

    // Response stage: capture the unit result when the matching tag emerges.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_quo   <= 50'd0;
            rsp_rem   <= 50'd0;
`ifdef MUL_DIV_ARB_DIVZ_CHK_EN
            rsp_dz    <= 1'b0;
`endif
        end else begin
            rsp_valid <= tag_out_s.valid;
            if (tag_out_s.valid) begin
                rsp_id <= tag_out_s.id;
`ifdef MUL_DIV_ARB_DIVZ_CHK_EN
                rsp_dz <= tag_out_s.dz;
`endif
                case (tag_out_s.op)
                    OP_MUL: begin
                        rsp_quo <= {2'b00, mul_prod};
                        rsp_rem <= 50'd0;
                    end
                    OP_DIV: begin
`ifdef MUL_DIV_ARB_DIVZ_CHK_EN
                        if (tag_out_s.dz) begin
                            rsp_quo <= {DIVIDEND_W{1'b1}};
                            rsp_rem <= dz_opa_r[LAT-1];
                        end else begin
                            rsp_quo <= div_quo;
                            rsp_rem <= div_rem;
                        end
`else
                        rsp_quo <= div_quo;
                        rsp_rem <= div_rem;
`endif
                    end
                    default: begin
                        rsp_quo <= rsp_quo;
                        rsp_rem <= rsp_rem;
                    end
                endcase
            end
        end
    end

    // Busy covers the operation being granted now, every tag stage and the response stage.
    always_comb begin
        busy = gnt_any_s | rsp_valid;
        for (int i = 0; i < LAT; i++) begin
            busy = busy | tag_r[i].valid;
        end
    end

endmodule

// File: tb/tb_mul_div_arb.sv
// Self-checking bench for mul_div_arb with LAT = 2 and registered unit models.
module tb_mul_div_arb;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_op;
    logic [49:0] req_opa0, req_opa1;
    logic [23:0] req_opb0, req_opb1;
    logic [23:0] mul_opa, mul_opb;
    logic [49:0] div_opa;
    logic [23:0] div_opb;
    logic [47:0] mul_prod;
    logic [49:0] div_quo, div_rem;
    logic        rsp_valid, rsp_id;
    logic [49:0] rsp_quo, rsp_rem;
    logic        busy;
    logic        rsp_dz;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    mul_div_arb #(.LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_opa0  (req_opa0),
        .req_opa1  (req_opa1),
        .req_opb0  (req_opb0),
        .req_opb1  (req_opb1),
        .mul_opa   (mul_opa),
        .mul_opb   (mul_opb),
        .div_opa   (div_opa),
        .div_opb   (div_opb),
        .mul_prod  (mul_prod),
        .div_quo   (div_quo),
        .div_rem   (div_rem),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_quo   (rsp_quo),
        .rsp_rem   (rsp_rem),
        .busy      (busy)
`ifdef MUL_DIV_ARB_DIVZ_CHK_EN
        ,
        .rsp_dz    (rsp_dz)
`endif
    );

`ifndef MUL_DIV_ARB_DIVZ_CHK_EN
    assign rsp_dz = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Unit models: operands registered by the DUT plus one stage here gives LAT = 2.
    always @(posedge clk) begin
        mul_prod <= {24'd0, mul_opa} * {24'd0, mul_opb};
        if (div_opb == 24'd0) begin
            div_quo <= {50{1'b1}};
            div_rem <= div_opa;
        end else begin
            div_quo <= div_opa / {26'd0, div_opb};
            div_rem <= div_opa % {26'd0, div_opb};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic        id;
        logic [49:0] quo;
        logic [49:0] rem;
        logic        dz;
    } exp_t;

    exp_t        sb[$];
    exp_t        item;
    logic        pref;
    logic [1:0]  eg;
    logic        had;
    logic        g_id, g_op;
    logic [49:0] g_a;
    logic [23:0] g_b;
    logic [49:0] last_quo, last_rem;
    logic        last_id, last_dz;
    logic [23:0] m_mul_a, m_mul_b, m_div_b;
    logic [49:0] m_div_a;

    function automatic exp_t predict(logic id, logic op, logic [49:0] a, logic [23:0] b, int due);
        exp_t e;
        longint unsigned ua, ub;
        e.due = due;
        e.id  = id;
        e.dz  = 1'b0;
        if (op == 1'b0) begin
            ua    = longint'(a[23:0]);
            ub    = longint'(b);
            e.quo = 50'(ua * ub);
            e.rem = 50'd0;
        end else if (b == 24'd0) begin
            e.quo = {50{1'b1}};
            e.rem = a;
            e.dz  = 1'b1;
        end else begin
            ua    = longint'(a);
            ub    = longint'(b);
            e.quo = 50'(ua / ub);
            e.rem = 50'(ua % ub);
        end
        return e;
    endfunction

    task automatic model_reset();
        sb.delete();
        pref     = 1'b0;
        last_quo = 50'd0;
        last_rem = 50'd0;
        last_id  = 1'b0;
        last_dz  = 1'b0;
        m_mul_a  = 24'd0;
        m_mul_b  = 24'd0;
        m_div_a  = 50'd0;
        m_div_b  = 24'd0;
    endtask

    // Per-cycle checker on the falling edge.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("ready_in_rst", {62'd0, req_ready}, 64'd0);
                model_reset();
            end else begin
                had = (sb.size() > 0);
                case (req_valid)
                    2'b01:   eg = 2'b01;
                    2'b10:   eg = 2'b10;
                    2'b11:   eg = pref ? 2'b10 : 2'b01;
                    default: eg = 2'b00;
                endcase
                chk("grant", {62'd0, req_ready}, {62'd0, eg});
                chk("busy", {63'd0, busy}, {63'd0, (eg != 2'b00) || had});
                chk("mul_opa", {40'd0, mul_opa}, {40'd0, m_mul_a});
                chk("mul_opb", {40'd0, mul_opb}, {40'd0, m_mul_b});
                chk("div_opa", {14'd0, div_opa}, {14'd0, m_div_a});
                chk("div_opb", {40'd0, div_opb}, {40'd0, m_div_b});
                if (had && sb[0].due == cyc) begin
                    item     = sb.pop_front();
                    last_quo = item.quo;
                    last_rem = item.rem;
                    last_id  = item.id;
                    last_dz  = item.dz;
                    chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
                end else begin
                    chk("rsp_valid", {63'd0, rsp_valid}, 64'd0);
                end
                chk("rsp_quo", {14'd0, rsp_quo}, {14'd0, last_quo});
                chk("rsp_rem", {14'd0, rsp_rem}, {14'd0, last_rem});
                chk("rsp_id", {63'd0, rsp_id}, {63'd0, last_id});
`ifdef MUL_DIV_ARB_DIVZ_CHK_EN
                chk("rsp_dz", {63'd0, rsp_dz}, {63'd0, last_dz});
`endif
                if (eg != 2'b00) begin
                    g_id = eg[1];
                    g_op = g_id ? req_op[1] : req_op[0];
                    g_a  = g_id ? req_opa1 : req_opa0;
                    g_b  = g_id ? req_opb1 : req_opb0;
                    sb.push_back(predict(g_id, g_op, g_a, g_b, cyc + LAT + 1));
                    pref = ~g_id;
                    if (g_op == 1'b0) begin
                        m_mul_a = g_a[23:0];
                        m_mul_b = g_b;
`ifdef MUL_DIV_ARB_DIVZ_CHK_EN
                    end else if (g_b != 24'd0) begin
`else
                    end else begin
`endif
                        m_div_a = g_a;
                        m_div_b = g_b;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] op,
                         input logic [49:0] a0, input logic [23:0] b0,
                         input logic [49:0] a1, input logic [23:0] b1);
        req_valid = v;
        req_op    = op;
        req_opa0  = a0;
        req_opb0  = b0;
        req_opa1  = a1;
        req_opb1  = b1;
    endtask

    function automatic logic [49:0] rand_opa();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0:       return {42'd0, r[7:0]};
            1:       return {26'd0, r[23:0]};
            default: return r[49:0];
        endcase
    endfunction

    function automatic logic [23:0] rand_opb();
        logic [31:0] r;
        logic [23:0] b;
        r = $urandom;
        b = ($urandom_range(0, 2) == 0) ? {16'd0, r[7:0]} : r[23:0];
`ifdef MUL_DIV_ARB_DIVZ_CHK_EN
        if ($urandom_range(0, 7) == 0) b = 24'd0;
`else
        if (b == 24'd0) b = 24'd1;
`endif
        return b;
    endfunction

    initial begin
        rst = 1'b1;
        drive(2'b11, 2'b00, 50'd1, 24'd1, 50'd2, 24'd2);
        repeat (3) step();
        rst = 1'b0;
        drive(2'b00, 2'b00, 50'd0, 24'd0, 50'd0, 24'd0);
        @(negedge clk);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_quo", {14'd0, rsp_quo}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);

        // Contention from the first cycle: grants alternate starting at requester 0.
        step();
        drive(2'b11, 2'b00, 50'd6, 24'd7, 50'd8, 24'd9);
        @(negedge clk);
        chk("first_grant", {62'd0, req_ready}, 64'd1);
        repeat (5) step();
        drive(2'b00, 2'b00, 50'd0, 24'd0, 50'd0, 24'd0);
        repeat (4) step();

        // Requester 0 multiply 3*5.
        drive(2'b01, 2'b00, 50'd3, 24'd5, 50'd0, 24'd0);
        step();
        drive(2'b00, 2'b00, 50'd0, 24'd0, 50'd0, 24'd0);
        step();
        step();
        @(negedge clk);
        chk("mul3x5_valid", {63'd0, rsp_valid}, 64'd1);
        chk("mul3x5_quo", {14'd0, rsp_quo}, 64'd15);
        chk("mul3x5_rem", {14'd0, rsp_rem}, 64'd0);
        chk("mul3x5_id", {63'd0, rsp_id}, 64'd0);

        // Requester 1 divide 100/7.
        step();
        drive(2'b10, 2'b10, 50'd0, 24'd0, 50'd100, 24'd7);
        step();
        drive(2'b00, 2'b00, 50'd0, 24'd0, 50'd0, 24'd0);
        step();
        step();
        @(negedge clk);
        chk("div100_valid", {63'd0, rsp_valid}, 64'd1);
        chk("div100_quo", {14'd0, rsp_quo}, 64'd14);
        chk("div100_rem", {14'd0, rsp_rem}, 64'd2);
        chk("div100_id", {63'd0, rsp_id}, 64'd1);

        // Two grants then reset: both responses must vanish.
        step();
        drive(2'b01, 2'b00, 50'd11, 24'd13, 50'd0, 24'd0);
        step();
        drive(2'b10, 2'b10, 50'd0, 24'd0, 50'd500, 24'd3);
        step();
        rst = 1'b1;
        drive(2'b00, 2'b00, 50'd0, 24'd0, 50'd0, 24'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_drop_a", {63'd0, rsp_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        step();
        drive(2'b11, 2'b11, 50'd77, 24'd5, 50'd88, 24'd4);
        @(negedge clk);
        chk("rst_drop_b", {63'd0, rsp_valid}, 64'd0);
        chk("rr_after_rst", {62'd0, req_ready}, 64'd1);
        step();
        drive(2'b00, 2'b00, 50'd0, 24'd0, 50'd0, 24'd0);
        repeat (4) step();

`ifdef MUL_DIV_ARB_DIVZ_CHK_EN
        // Divide by zero is answered locally.
        drive(2'b01, 2'b01, 50'd9, 24'd0, 50'd0, 24'd0);
        step();
        drive(2'b00, 2'b00, 50'd0, 24'd0, 50'd0, 24'd0);
        step();
        step();
        @(negedge clk);
        chk("dz_valid", {63'd0, rsp_valid}, 64'd1);
        chk("dz_flag", {63'd0, rsp_dz}, 64'd1);
        chk("dz_quo", {14'd0, rsp_quo}, 64'h3FFFFFFFFFFFF);
        chk("dz_rem", {14'd0, rsp_rem}, 64'd9);
        step();
`endif

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            drive(2'($urandom), 2'($urandom), rand_opa(), rand_opb(), rand_opa(), rand_opb());
            step();
        end
        rst = 1'b0;
        drive(2'b00, 2'b00, 50'd0, 24'd0, 50'd0, 24'd0);
        repeat (6) step();
        @(negedge clk);
        chk("drain_busy", {63'd0, busy}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
